// File: rtl/resamp_out_fifo.sv
`default_nettype none
// ============================================================================
// Module   : resamp_out_fifo
// Brief    : Output rate buffer behind the L/D polyphase resampler. Captures
//            each RDY-strobed sample with its OV tag and presents it
//            first-word-fall-through on a valid/ready interface. Keeps a
//            saturating drop counter and sticky OV/drop status.
// Revision : 1.0 - initial release
// ============================================================================
module resamp_out_fifo #(
  parameter int WORD_SIZE = 16,
  parameter int DEPTH     = 16,
  parameter int ADDR_BITS = 4,
  parameter int AFULL_LVL = 12,
  parameter int DROP_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WORD_SIZE-1:0] i_din,
  input  logic                 i_din_ov,
  input  logic                 i_wr,
  output logic [WORD_SIZE-1:0] o_dout,
  output logic                 o_dout_ov,
  output logic                 o_dvalid,
  input  logic                 i_dready,
  output logic [ADDR_BITS:0]   o_level,
  output logic                 o_afull,
  output logic [DROP_BITS-1:0] o_drop_cnt,
  output logic                 o_ov_seen,
  output logic                 o_drop_seen,
  input  logic                 i_clr_stat
);

  localparam logic [ADDR_BITS:0]   c_FULL_LVL  = (ADDR_BITS+1)'(DEPTH);
  localparam logic [ADDR_BITS:0]   c_AFULL_LVL = (ADDR_BITS+1)'(AFULL_LVL);
  localparam logic [DROP_BITS-1:0] c_DROP_MAX  = '1;

  // Storage: {ov, sample} per entry; contents need no reset.
  logic [WORD_SIZE:0]   r_mem [DEPTH];
  logic [ADDR_BITS-1:0] r_wr_ptr;
  logic [ADDR_BITS-1:0] r_rd_ptr;
  logic [ADDR_BITS:0]   r_level;
  logic                 r_afull;
  logic [DROP_BITS-1:0] r_drop_cnt;
  logic                 r_ov_seen;
  logic                 r_drop_seen;

  logic                 w_not_empty;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_drop;
  logic [ADDR_BITS:0]   w_level_nxt;
  logic [WORD_SIZE:0]   w_head;

  // Handshake decode: a pop frees a slot in the same edge, so full+pop+wr pushes.
  always_comb begin
    w_not_empty = (r_level != '0);
    w_pop       = w_not_empty & i_dready;
    w_push      = i_wr & ((r_level != c_FULL_LVL) | w_pop);
    w_drop      = i_wr & ~w_push;
    w_level_nxt = r_level;
    if (w_push && !w_pop) begin
      w_level_nxt = r_level + 1'b1;
    end else if (w_pop && !w_push) begin
      w_level_nxt = r_level - 1'b1;
    end
  end

  // Sample storage write port.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {i_din_ov, i_din};
    end
  end

  // Pointers, occupancy and the almost-full flag (registered from next level).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_afull  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_level <= w_level_nxt;
      r_afull <= (w_level_nxt >= c_AFULL_LVL);
    end
  end

  // Statistics: an event in the same cycle as CLR_STAT takes precedence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt  <= '0;
      r_drop_seen <= 1'b0;
      r_ov_seen   <= 1'b0;
    end else begin
      if (w_drop) begin
        if (i_clr_stat) begin
          r_drop_cnt <= DROP_BITS'(1);
        end else if (r_drop_cnt != c_DROP_MAX) begin
          r_drop_cnt <= r_drop_cnt + 1'b1;
        end
        r_drop_seen <= 1'b1;
      end else if (i_clr_stat) begin
        r_drop_cnt  <= '0;
        r_drop_seen <= 1'b0;
      end
      if (w_push && i_din_ov) begin
        r_ov_seen <= 1'b1;
      end else if (i_clr_stat) begin
        r_ov_seen <= 1'b0;
      end
    end
  end

  // First-word-fall-through read; output forced to zero while empty.
  always_comb begin
    w_head = '0;
    if (w_not_empty) begin
      w_head = r_mem[r_rd_ptr];
    end
  end

  assign o_dout      = w_head[WORD_SIZE-1:0];
  assign o_dout_ov   = w_head[WORD_SIZE];
  assign o_dvalid    = w_not_empty;
  assign o_level     = r_level;
  assign o_afull     = r_afull;
  assign o_drop_cnt  = r_drop_cnt;
  assign o_ov_seen   = r_ov_seen;
  assign o_drop_seen = r_drop_seen;

endmodule
`default_nettype wire

// File: tb/tb_resamp_out_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_resamp_out_fifo
// Brief    : Self-checking bench for resamp_out_fifo: directed scenarios plus
//            randomized traffic against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_resamp_out_fifo;

  localparam int c_W     = 16;
  localparam int c_DEPTH = 16;
  localparam int c_AFULL = 12;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [c_W-1:0]  r_din = '0;
  logic            r_din_ov = 1'b0;
  logic            r_wr = 1'b0;
  logic            r_dready = 1'b0;
  logic            r_clr = 1'b0;
  logic [c_W-1:0]  w_dout;
  logic            w_dout_ov;
  logic            w_dvalid;
  logic [4:0]      w_level;
  logic            w_afull;
  logic [15:0]     w_drop_cnt;
  logic            w_ov_seen;
  logic            w_drop_seen;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [c_W:0] m_q[$];
  int           m_drop;
  bit           m_ov_seen;
  bit           m_drop_seen;

  resamp_out_fifo #(
    .WORD_SIZE(16), .DEPTH(16), .ADDR_BITS(4), .AFULL_LVL(12), .DROP_BITS(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_din(r_din), .i_din_ov(r_din_ov), .i_wr(r_wr),
    .o_dout(w_dout), .o_dout_ov(w_dout_ov), .o_dvalid(w_dvalid),
    .i_dready(r_dready), .o_level(w_level), .o_afull(w_afull),
    .o_drop_cnt(w_drop_cnt), .o_ov_seen(w_ov_seen), .o_drop_seen(w_drop_seen),
    .i_clr_stat(r_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_drop      = 0;
    m_ov_seen   = 0;
    m_drop_seen = 0;
  endtask

  // Compare every observable output against the model.
  task automatic chk_all(input string tag);
    logic [c_W:0] head;
    head = (m_q.size() != 0) ? m_q[0] : '0;
    chk({tag, ".dvalid"},    32'(w_dvalid),    32'(m_q.size() != 0));
    chk({tag, ".dout"},      32'(w_dout),      32'(head[c_W-1:0]));
    chk({tag, ".dout_ov"},   32'(w_dout_ov),   32'(head[c_W]));
    chk({tag, ".level"},     32'(w_level),     32'(m_q.size()));
    chk({tag, ".afull"},     32'(w_afull),     32'(m_q.size() >= c_AFULL));
    chk({tag, ".drop_cnt"},  32'(w_drop_cnt),  32'(m_drop));
    chk({tag, ".ov_seen"},   32'(w_ov_seen),   32'(m_ov_seen));
    chk({tag, ".drop_seen"}, 32'(w_drop_seen), 32'(m_drop_seen));
  endtask

  // One clock: apply inputs, advance model by the stated rules, check after the edge.
  task automatic step(input string tag, input bit wr, input logic [c_W-1:0] din,
                      input bit ov, input bit rdy, input bit clr);
    bit pop, push, drop;
    r_wr = wr; r_din = din; r_din_ov = ov; r_dready = rdy; r_clr = clr;
    @(posedge clk);
    pop  = (m_q.size() > 0) && rdy;
    push = wr && ((m_q.size() < c_DEPTH) || pop);
    drop = wr && !push;
    if (pop)  void'(m_q.pop_front());
    if (push) m_q.push_back({ov, din});
    if (clr) begin
      m_drop = 0; m_drop_seen = 0; m_ov_seen = 0;
    end
    if (drop) begin
      if (m_drop < 65535) m_drop++;
      m_drop_seen = 1;
    end
    if (push && ov) m_ov_seen = 1;
    #1;
    chk_all(tag);
  endtask

  // Reset held with WR active; released with WR idle.
  task automatic do_reset();
    r_wr = 1'b1; r_din = 16'hdead; r_din_ov = 1'b1; r_dready = 1'b0; r_clr = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    model_clear();
    chk_all("rst_async");
    repeat (2) @(posedge clk);
    #1;
    chk_all("rst_hold");
    @(negedge clk);
    r_wr = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    model_clear();
    // T1: reset with WR active, no write after release
    do_reset();
    step("T1_idle", 0, '0, 0, 0, 0);

    // T2: single-write latency
    step("T2_wr", 1, 16'h1234, 0, 0, 0);
    chk("T2_dout", 32'(w_dout), 32'h1234);
    chk("T2_level", 32'(w_level), 32'd1);

    // T3: ordered streaming with wrap, DREADY toggling
    do_reset();
    for (int k = 0; k < 40; k++) step("T3_wr", 1, 16'(k), 0, (k % 2) == 0, 0);
    for (int k = 0; k < 60 && m_q.size() != 0; k++) step("T3_drain", 0, '0, 0, 1, 0);
    chk("T3_empty", 32'(w_dvalid), 32'd0);

    // T4: overfill without reads
    do_reset();
    for (int k = 0; k < 20; k++) step("T4_wr", 1, 16'(16'h100 + k), 0, 0, 0);
    chk("T4_level", 32'(w_level), 32'd16);
    chk("T4_afull", 32'(w_afull), 32'd1);
    chk("T4_drop", 32'(w_drop_cnt), 32'd4);
    chk("T4_dseen", 32'(w_drop_seen), 32'd1);
    chk("T4_head", 32'(w_dout), 32'h100);

    // T5: full with simultaneous pop and push
    step("T5_pp", 1, 16'h5555, 0, 1, 0);
    chk("T5_level", 32'(w_level), 32'd16);
    chk("T5_drop", 32'(w_drop_cnt), 32'd4);

    // T6: OV tag and clear-vs-event priority
    do_reset();
    step("T6_ov", 1, 16'h0abc, 1, 0, 0);
    chk("T6_ovseen", 32'(w_ov_seen), 32'd1);
    chk("T6_doutov", 32'(w_dout_ov), 32'd1);
    for (int k = 0; k < 17; k++) step("T6_fill", 1, 16'(k), 0, 0, 0);
    step("T6_clrdrop", 1, 16'h7777, 1, 0, 1);
    chk("T6_drop1", 32'(w_drop_cnt), 32'd1);
    step("T6_clr", 0, '0, 0, 0, 1);
    chk("T6_clr0", 32'(w_drop_cnt), 32'd0);

    // Randomized traffic in segments with varying write/read pressure
    do_reset();
    for (int s = 0; s < 16; s++) begin
      int wr_pct, rd_pct;
      wr_pct = $urandom_range(20, 100);
      rd_pct = $urandom_range(0, 100);
      for (int k = 0; k < 150; k++) begin
        step("RND",
             $urandom_range(0, 99) < wr_pct,
             16'($urandom),
             $urandom_range(0, 9) == 0,
             $urandom_range(0, 99) < rd_pct,
             $urandom_range(0, 49) == 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
